// File: rtl/shift_engine.sv
// Sequential shift/rotate engine: one bit per cycle over a WIDTH-bit register,
// with parallel load of the low LOAD_W bits and a busy/done handshake.
module shift_engine #(
  parameter  int WIDTH  = 16,
  parameter  int LOAD_W = 8,
  localparam int AW     = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [AW-1:0]     amt,
  input  logic              load,
  input  logic [LOAD_W-1:0] D,
  output logic [WIDTH-1:0]  Q,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n, q_loaded, q_shifted;
  logic [AW-1:0]    cnt, cnt_n, amt_eff;
  logic [1:0]       mode_r, mode_r_n;
  logic             busy_n, done_n;

  // Slicing Q[WIDTH-1:LOAD_W] is illegal when LOAD_W == WIDTH, so the two
  // shapes are elaborated separately.
  generate
    if (LOAD_W == WIDTH) begin : g_full_load
      assign q_loaded = D;
    end else begin : g_part_load
      assign q_loaded = {Q[WIDTH-1:LOAD_W], D};
    end
  endgenerate

  // Amounts past the top bit only exist for non-power-of-2 widths; saturate.
  assign amt_eff = (int'(amt) > WIDTH - 1) ? AMT_MAX : amt;

  always_comb begin
    case (mode_r)
      2'b00:   q_shifted = {Q[0], Q[WIDTH-1:1]};
      2'b01:   q_shifted = {Q[WIDTH-2:0], Q[WIDTH-1]};
      2'b10:   q_shifted = {1'b0, Q[WIDTH-1:1]};
      default: q_shifted = {Q[WIDTH-1], Q[WIDTH-1:1]};
    endcase
  end

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    q_n      = Q;
    cnt_n    = cnt;
    mode_r_n = mode_r;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          mode_r_n = mode;
          cnt_n    = amt_eff;
          state_n  = SHIFT;
        end else if (load) begin
          q_n = q_loaded;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          q_n   = q_shifted;
          cnt_n = cnt - AW'(1);
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      Q      <= '0;
      cnt    <= '0;
      mode_r <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      Q      <= q_n;
      cnt    <= cnt_n;
      mode_r <= mode_r_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Directed-vector bench for shift_engine (WIDTH=16, LOAD_W=8); expected
// values are hand-computed.
module tb_shift_engine;

  logic        clk = 1'b0;
  logic        R;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  amt;
  logic        load;
  logic [7:0]  D;
  logic [15:0] Q;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_engine #(.WIDTH(16), .LOAD_W(8)) dut (
    .clk   (clk),
    .R     (R),
    .start (start),
    .mode  (mode),
    .amt   (amt),
    .load  (load),
    .D     (D),
    .Q     (Q),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; R is low well clear of both edges.
  task automatic reset_pulse();
    R = 1'b0;
    #2;
    R = 1'b1;
  endtask

  // Waits (bounded) for done; optionally throws start/load/garbage at the
  // engine during its first busy cycle.
  task automatic wait_done(input bit garbage, output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (garbage && i == 0) begin
        start = 1'b1;
        load  = 1'b1;
        D     = 8'hFF;
        mode  = 2'b01;
        amt   = 4'hF;
      end
      tick();
      start = 1'b0;
      load  = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [3:0] a,
                        input bit garbage, input logic [15:0] exp_q, input int exp_busy);
    int bc;
    bit got;
    start = 1'b1;
    mode  = m;
    amt   = a;
    tick();
    start = 1'b0;
    wait_done(garbage, bc, got);
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, "_q"}, 32'(Q), 32'(exp_q));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  bc;
    bit  got;
    bit  done_seen;

    R     = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    amt   = 4'd0;
    load  = 1'b0;
    D     = 8'h00;
    #2;
    check("rst_q", 32'(Q), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    R = 1'b1;
    tick();

    load = 1'b1;
    D    = 8'hA5;
    tick();
    load = 1'b0;
    check("load_a5", 32'(Q), 32'h00A5);
    run_op("ror4", 2'b00, 4'd4, 1'b0, 16'h500A, 5);

    // Abort a shift with an asynchronous reset between edges.
    start = 1'b1;
    mode  = 2'b00;
    amt   = 4'd4;
    tick();
    start = 1'b0;
    check("abort_pre_q", 32'(Q), 32'h500A);
    check("abort_pre_busy", 32'(busy), 32'd1);
    #3;
    R = 1'b0;
    #1;
    check("abort_q", 32'(Q), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    #1;
    R = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_seen = 1'b1;
    end
    check("abort_no_resume", 32'(done_seen), 32'd0);
    check("abort_q_after", 32'(Q), 32'h0);

    load = 1'b1;
    D    = 8'hA5;
    tick();
    load = 1'b0;
    check("reload_a5", 32'(Q), 32'h00A5);
    run_op("rol4", 2'b01, 4'd4, 1'b0, 16'h0A50, 5);

    // Load applied at the first edge after reset release must take effect.
    reset_pulse();
    load = 1'b1;
    D    = 8'h01;
    tick();
    load = 1'b0;
    check("load_at_release", 32'(Q), 32'h0001);
    run_op("rol15", 2'b01, 4'd15, 1'b0, 16'h8000, 16);
    run_op("asr3", 2'b11, 4'd3, 1'b0, 16'hF000, 4);

    reset_pulse();
    load = 1'b1;
    D    = 8'h01;
    tick();
    load = 1'b0;
    run_op("ror1", 2'b00, 4'd1, 1'b0, 16'h8000, 2);
    run_op("lsr3", 2'b10, 4'd3, 1'b0, 16'h1000, 4);

    // start wins over load; amt=0 gives one busy cycle then done.
    load = 1'b1;
    D    = 8'hFF;
    run_op("start_load_amt0", 2'b00, 4'd0, 1'b0, 16'h1000, 1);

    // Inputs toggled while busy must not disturb Q or the latched amount.
    run_op("ignore_busy", 2'b10, 4'd2, 1'b1, 16'h0400, 3);

    // Back-to-back: restart in the done cycle.
    start = 1'b1;
    mode  = 2'b00;
    amt   = 4'd1;
    tick();
    start = 1'b0;
    wait_done(1'b0, bc, got);
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_q", 32'(Q), 32'h0200);
    start = 1'b1;
    mode  = 2'b01;
    amt   = 4'd2;
    tick();
    start = 1'b0;
    check("b2b_busy_rise", 32'(busy), 32'd1);
    check("b2b_done_fall", 32'(done), 32'd0);
    wait_done(1'b0, bc, got);
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_busy_cycles", 32'(bc), 32'd3);
    check("b2b_second_q", 32'(Q), 32'h0800);
    tick();
    check("b2b_done_single", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width; legal range 2..64.
REQ-002 SHALL have parameter LOAD_W, default 8, parallel-load width; legal range 1..WIDTH.
REQ-003 SHALL derive AW = $clog2(WIDTH), the width of amt.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port R  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a shift operation.
REQ-007 SHALL have port mode  input  2  operation select: 00 rotate right, 01 rotate left, 10 logical shift right, 11 arithmetic shift right.
REQ-008 SHALL have port amt  input  AW  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port load  input  1  parallel load of the low LOAD_W bits.
REQ-010 SHALL have port D  input  LOAD_W  load data.
REQ-011 SHALL have port Q  output  WIDTH  register contents, registered.
REQ-012 SHALL have port busy  output  1  operation in progress, registered.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse, registered.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, with start=1, SHALL latch mode and amt into internal registers, load the counter with amt, enter SHIFT, and set busy=1.
REQ-016 In IDLE or DONE, with load=1 and start=0, SHALL set Q to {Q[WIDTH-1:LOAD_W], D}, leaving the upper bits unchanged; when LOAD_W=WIDTH, Q becomes D.
REQ-017 When start and load are both 1, start SHALL win and the load SHALL be discarded.
REQ-018 In SHIFT, with counter != 0, SHALL shift Q by one bit per cycle according to the latched mode and decrement the counter.
REQ-019 In SHIFT, with counter == 0, SHALL leave Q unchanged, enter DONE, and set busy=0, done=1.
REQ-020 Rotate right SHALL set the new MSB to the old Q[0]; rotate left SHALL set the new LSB to the old Q[WIDTH-1]; logical shift right SHALL shift in 0 at the MSB; arithmetic shift right SHALL replicate the old MSB.
REQ-021 Latency SHALL be as follows: start sampled at edge k; shifts occur at edges k+1..k+amt; done=1 between edges k+amt+1 and k+amt+2; busy=1 between edges k and k+amt+1.
REQ-022 amt=0 SHALL leave Q unchanged, with busy high for 1 cycle followed by a done pulse.
REQ-023 While busy=1, start, load, mode, amt and D SHALL be ignored.
REQ-024 done SHALL be high for exactly one cycle per accepted start; DONE returns to IDLE on the next edge unless a new start is accepted there.
REQ-025 A start accepted in DONE SHALL give back-to-back operation with no idle cycle; done falls and busy rises at the same edge.
REQ-026 amt values >= WIDTH (possible only when WIDTH is not a power of 2) SHALL be treated as WIDTH-1.
REQ-027 Outputs SHALL have no combinational path from inputs.

Reset
REQ-028 R=0 SHALL immediately, without waiting for a clock edge, set Q=0, busy=0, done=0, the counter to 0, the latched mode to 00, and the state to IDLE.
REQ-029 Assertion of R during SHIFT SHALL abort the operation; after R returns to 1, no shifting resumes and no done pulse is produced.
REQ-030 Release of R SHALL take effect at the first rising clk edge at which R=1; inputs sampled at that edge are acted on normally.

Verification (WIDTH=16, LOAD_W=8)
REQ-031 SHALL cover: R=0 asserted between clock edges mid-SHIFT with Q=0x500A -> Q=0x0000, busy=0, done=0 before the next edge, with no done after release.
REQ-032 SHALL cover: Q=0x0000, load D=0xA5 -> Q=0x00A5; then start, mode=00, amt=4 -> Q=0x500A, busy for 5 cycles, then a single done pulse.
REQ-033 SHALL cover: Q=0x00A5, start, mode=01, amt=4 -> Q=0x0A50; then start, mode=01, amt=15 from Q=0x0001 -> Q=0x8000.
REQ-034 SHALL cover: Q=0x8000, start, mode=11, amt=3 -> Q=0xF000; from Q=0x8000, start, mode=10, amt=3 -> Q=0x1000.
REQ-035 SHALL cover: start and load both 1 with amt=0 -> Q unchanged, done 2 cycles after start; load or start pulsed while busy -> no effect on Q or on the latched amt.
REQ-036 SHALL cover: a start asserted in the done cycle -> a second operation begins with no idle cycle, and both done pulses are observed.
